// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: set-2 scan codes, the team's 8-bit key codes,
// FSM state types and small helpers used by the encoder and interpreter.
package ps2_pkg;

    // PS/2 set-2 scan-code bytes
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;

    // Key codes produced by the keyboard interpreter
    localparam logic [7:0] KEY_W_PRESS       = 8'h57;
    localparam logic [7:0] KEY_S_PRESS       = 8'h53;
    localparam logic [7:0] KEY_A_PRESS       = 8'h41;
    localparam logic [7:0] KEY_D_PRESS       = 8'h44;
    localparam logic [7:0] KEY_UP_PRESS      = 8'h30;
    localparam logic [7:0] KEY_DOWN_PRESS    = 8'h31;
    localparam logic [7:0] KEY_LEFT_PRESS    = 8'h32;
    localparam logic [7:0] KEY_RIGHT_PRESS   = 8'h33;
    localparam logic [7:0] KEY_W_RELEASE     = 8'h77;
    localparam logic [7:0] KEY_S_RELEASE     = 8'h73;
    localparam logic [7:0] KEY_A_RELEASE     = 8'h61;
    localparam logic [7:0] KEY_D_RELEASE     = 8'h64;
    localparam logic [7:0] KEY_UP_RELEASE    = 8'h2B;
    localparam logic [7:0] KEY_DOWN_RELEASE  = 8'h2D;
    localparam logic [7:0] KEY_LEFT_RELEASE  = 8'h2F;
    localparam logic [7:0] KEY_RIGHT_RELEASE = 8'h2A;
    localparam logic [7:0] KEY_NONE          = 8'h3F;

    // Byte sequence for one key code; len == 0 means the code is unmapped
    typedef struct packed {
        logic [1:0] len;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } scan_seq_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_BIT_HI,
        TX_BIT_LO,
        TX_GAP
    } tx_state_t;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_SEND
    } seq_state_t;

    // Map a key code to its scan-code byte sequence
    function automatic scan_seq_t keycode_to_scan(input logic [7:0] code);
        scan_seq_t s;
        s = '0;
        case (code)
            KEY_W_PRESS:       s = {2'd1, SC_W,     8'h00,    8'h00};
            KEY_S_PRESS:       s = {2'd1, SC_S,     8'h00,    8'h00};
            KEY_A_PRESS:       s = {2'd1, SC_A,     8'h00,    8'h00};
            KEY_D_PRESS:       s = {2'd1, SC_D,     8'h00,    8'h00};
            KEY_UP_PRESS:      s = {2'd2, SC_EXT,   SC_UP,    8'h00};
            KEY_DOWN_PRESS:    s = {2'd2, SC_EXT,   SC_DOWN,  8'h00};
            KEY_LEFT_PRESS:    s = {2'd2, SC_EXT,   SC_LEFT,  8'h00};
            KEY_RIGHT_PRESS:   s = {2'd2, SC_EXT,   SC_RIGHT, 8'h00};
            KEY_W_RELEASE:     s = {2'd2, SC_BREAK, SC_W,     8'h00};
            KEY_S_RELEASE:     s = {2'd2, SC_BREAK, SC_S,     8'h00};
            KEY_A_RELEASE:     s = {2'd2, SC_BREAK, SC_A,     8'h00};
            KEY_D_RELEASE:     s = {2'd2, SC_BREAK, SC_D,     8'h00};
            KEY_UP_RELEASE:    s = {2'd3, SC_EXT,   SC_BREAK, SC_UP};
            KEY_DOWN_RELEASE:  s = {2'd3, SC_EXT,   SC_BREAK, SC_DOWN};
            KEY_LEFT_RELEASE:  s = {2'd3, SC_EXT,   SC_BREAK, SC_LEFT};
            KEY_RIGHT_RELEASE: s = {2'd3, SC_EXT,   SC_BREAK, SC_RIGHT};
            default:           s = '0;
        endcase
        return s;
    endfunction

    // 11-bit PS/2 frame, bit 0 sent first: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Device-side PS/2 byte serializer: one frame per start pulse, followed by an
// idle gap. done is high during the last gap cycle, when a new start may chain.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV  = 2000,
    parameter int BYTE_GAP = 5000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] tx_byte,
    input  logic       start,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int CNT_MAX = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BYTE_GAP - 1);
    localparam logic [3:0]       LAST_BIT  = 4'd10;

    tx_state_t        state;
    logic [CNT_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [10:0]      frame;
    logic [7:0]       data_q;
    logic [10:0]      load_frame;

    assign load_frame = ps2_frame(data_q);
    assign done       = (state == TX_GAP) && (div_cnt == GAP_LAST);

    // Serializer FSM: frame is a shift register whose bit 0 is the next bit to drive
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= TX_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            frame    <= '1;
            data_q   <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        data_q <= tx_byte;
                        state  <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    ps2_data <= load_frame[0];
                    frame    <= {1'b1, load_frame[10:1]};
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    ps2_clk  <= 1'b1;
                    state    <= TX_BIT_HI;
                end
                TX_BIT_HI: begin
                    if (div_cnt == HALF_LAST) begin
                        div_cnt <= '0;
                        ps2_clk <= 1'b0;
                        state   <= TX_BIT_LO;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                TX_BIT_LO: begin
                    if (div_cnt == HALF_LAST) begin
                        div_cnt <= '0;
                        ps2_clk <= 1'b1;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            ps2_data <= 1'b1;
                            state    <= TX_GAP;
                        end else begin
                            ps2_data <= frame[0];
                            frame    <= {1'b1, frame[10:1]};
                            state    <= TX_BIT_HI;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                TX_GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt <= '0;
                        if (start) begin
                            data_q <= tx_byte;
                            state  <= TX_LOAD;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keycode_encoder.sv
// Turns team key codes into PS/2 set-2 byte sequences and drives them out as
// device-side frames. Bytes are latched at acceptance; busy inputs are ignored.
module ps2_keycode_encoder
    import ps2_pkg::*;
#(
    parameter int CLK_DIV  = 2000,
    parameter int BYTE_GAP = 5000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_code,
    input  logic       i_code_valid,
    output logic       o_ready,
    output logic       o_ps2_clk,
    output logic       o_ps2_data,
    output logic       o_busy,
    output logic       o_error
);

    seq_state_t seq_state;
    scan_seq_t  seq_buf;
    scan_seq_t  lookup;
    logic [1:0] byte_idx;
    logic [1:0] next_idx;
    logic       accept;
    logic       mapped;
    logic       more;
    logic       tx_start;
    logic       tx_done;
    logic [7:0] tx_byte;

    assign lookup   = keycode_to_scan(i_code);
    assign mapped   = (lookup.len != 2'd0);
    assign o_ready  = (seq_state == SEQ_IDLE);
    assign o_busy   = ~o_ready;
    assign accept   = i_code_valid && o_ready;
    assign next_idx = byte_idx + 2'd1;
    assign more     = (next_idx < seq_buf.len);

    // Start the serializer on a fresh mapped code, or chain the next buffered byte
    always_comb begin
        tx_start = 1'b0;
        tx_byte  = lookup.b0;
        if (accept && mapped) begin
            tx_start = 1'b1;
            tx_byte  = lookup.b0;
        end else if ((seq_state == SEQ_SEND) && tx_done && more) begin
            tx_start = 1'b1;
            case (next_idx)
                2'd0:    tx_byte = seq_buf.b0;
                2'd1:    tx_byte = seq_buf.b1;
                default: tx_byte = seq_buf.b2;
            endcase
        end
    end

    // Byte sequencer: latch the sequence at acceptance and walk it one frame at a time
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            seq_state <= SEQ_IDLE;
            seq_buf   <= '0;
            byte_idx  <= '0;
            o_error   <= 1'b0;
        end else begin
            o_error <= accept && !mapped;
            case (seq_state)
                SEQ_IDLE: begin
                    if (accept && mapped) begin
                        seq_buf   <= lookup;
                        byte_idx  <= '0;
                        seq_state <= SEQ_SEND;
                    end
                end
                SEQ_SEND: begin
                    if (tx_done) begin
                        byte_idx <= next_idx;
                        if (!more) begin
                            seq_state <= SEQ_IDLE;
                        end
                    end
                end
                default: seq_state <= SEQ_IDLE;
            endcase
        end
    end

    ps2_frame_tx #(
        .CLK_DIV  (CLK_DIV),
        .BYTE_GAP (BYTE_GAP)
    ) u_frame_tx (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .tx_byte  (tx_byte),
        .start    (tx_start),
        .done     (tx_done),
        .ps2_clk  (o_ps2_clk),
        .ps2_data (o_ps2_data)
    );

endmodule
